main_mem_responder: RTL and testbench

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/main_mem_responder.sv | 124 ++++++++++++
 tb/tb_main_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_responder.sv
// Line-wide backing store answering one read/write at a time; mem_ready LATENCY cycles after accept.
// Strobes outside IDLE are dropped and flagged on sticky req_err; stats counters under MAIN_MEM_STATS_EN.
module main_mem_responder #(
  parameter int LATENCY       = 4,
  parameter int LINE_IDX_BITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_wdata,
  input  logic         mem_read_req,
  input  logic         mem_write_req,
  output logic [511:0] mem_rdata,
  output logic         mem_ready,
  output logic         mem_busy,
  output logic         req_err,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR, RESP} state_t;

  localparam logic [7:0] LOAD = 8'(LATENCY - 1);

  state_t                   state, state_nxt;
  logic [7:0]               cnt, cnt_nxt;
  logic                     lat_rd;
  logic [LINE_IDX_BITS-1:0] lat_idx;
  logic [3:0]               lat_word;
  logic [31:0]              lat_wdata;
  logic                     accept, err_evt, enter_resp;
  logic                     op_rd;
  logic [LINE_IDX_BITS-1:0] op_idx;
  logic [3:0]               op_word;
  logic [31:0]              op_wdata;

  logic [511:0] store [0:(1<<LINE_IDX_BITS)-1];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:6+LINE_IDX_BITS], mem_addr[1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    err_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read_req || mem_write_req) begin
          accept    = 1'b1;
          err_evt   = mem_read_req && mem_write_req;
          cnt_nxt   = LOAD;
          state_nxt = (LATENCY == 1) ? RESP : (mem_read_req ? BUSY_RD : BUSY_WR);
        end
      end
      BUSY_RD, BUSY_WR: begin
        err_evt = mem_read_req || mem_write_req;
        cnt_nxt = cnt - 8'd1;
        // Leave when the decremented count hits zero so RESP lands exactly LATENCY cycles after accept.
        if (cnt <= 8'd1) state_nxt = RESP;
      end
      RESP: begin
        err_evt   = mem_read_req || mem_write_req;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 RESP is entered straight from IDLE, before anything is latched.
  assign op_rd      = (state == IDLE) ? mem_read_req : lat_rd;
  assign op_idx     = (state == IDLE) ? mem_addr[6 +: LINE_IDX_BITS] : lat_idx;
  assign op_word    = (state == IDLE) ? mem_addr[5:2] : lat_word;
  assign op_wdata   = (state == IDLE) ? mem_wdata : lat_wdata;
  assign enter_resp = (state_nxt == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      mem_rdata <= '0;
      req_err   <= 1'b0;
      lat_rd    <= 1'b0;
      lat_idx   <= '0;
      lat_word  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (err_evt) req_err <= 1'b1;
      if (accept) begin
        lat_rd    <= mem_read_req;
        lat_idx   <= mem_addr[6 +: LINE_IDX_BITS];
        lat_word  <= mem_addr[5:2];
        lat_wdata <= mem_wdata;
      end
      if (enter_resp && op_rd) mem_rdata <= store[op_idx];
    end
  end

  // Store survives reset; a write aborted by reset never commits.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && !op_rd) store[op_idx][{op_word, 5'd0} +: 32] <= op_wdata;
  end

  assign mem_ready = (state == RESP);
  assign mem_busy  = (state == BUSY_RD) || (state == BUSY_WR) || ((state == RESP) && (LATENCY > 1));

`ifdef MAIN_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (enter_resp) begin
      if (op_rd && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (!op_rd && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized + directed check of main_mem_responder (LATENCY=4 and LATENCY=1 instances) against a line/word model.
module tb_main_mem_responder;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_read_req, mem_write_req;
  logic [511:0] mem_rdata;
  logic mem_ready, mem_busy, req_err;
  logic [15:0] rd_count, wr_count;

  logic [31:0] b_addr, b_wdata;
  logic b_read_req, b_write_req;
  logic [511:0] b_rdata;
  logic b_ready, b_busy, b_err;
  logic [15:0] b_rd_count, b_wr_count;

  int total = 0;
  int bad = 0;
  logic [31:0] mdl  [256][16];
  logic [31:0] mdl1 [256][16];
  logic [511:0] last_rd;
  bit exp_err;
  int exp_rd, exp_wr, b_rd, b_wr;

`ifdef MAIN_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  main_mem_responder #(.LATENCY(L), .LINE_IDX_BITS(8)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_busy(mem_busy),
    .req_err(req_err), .rd_count(rd_count), .wr_count(wr_count));

  main_mem_responder #(.LATENCY(1), .LINE_IDX_BITS(8)) dut1 (
    .clk(clk), .rst(rst), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_read_req(b_read_req), .mem_write_req(b_write_req),
    .mem_rdata(b_rdata), .mem_ready(b_ready), .mem_busy(b_busy),
    .req_err(b_err), .rd_count(b_rd_count), .wr_count(b_wr_count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] line4(input int ln);
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[32*w +: 32] = mdl[ln][w];
    return v;
  endfunction

  function automatic logic [511:0] line1(input int ln);
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[32*w +: 32] = mdl1[ln][w];
    return v;
  endfunction

  function automatic logic [15:0] cnt_exp(input int n);
    if (!STATS) return 16'd0;
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  // Entered and left at a negedge with the DUT idle. inj>0 strobes again in busy/resp cycle inj.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input int inj);
    int ln, wd;
    ln = int'(addr[13:6]);
    wd = int'(addr[5:2]);
    mem_read_req = rd; mem_write_req = wr; mem_addr = addr; mem_wdata = data;
    if (rd && wr) exp_err = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= L; k++) begin
      mem_read_req = 1'b0; mem_write_req = 1'b0;
      if (k == L) begin
        if (rd) begin last_rd = line4(ln); exp_rd++; end
        else begin mdl[ln][wd] = data; exp_wr++; end
      end
      check($sformatf("ready_c%0d", k), {511'd0, mem_ready}, {511'd0, k == L});
      check($sformatf("busy_c%0d", k), {511'd0, mem_busy}, 512'd1);
      check("rdata", mem_rdata, last_rd);
      check("req_err", {511'd0, req_err}, {511'd0, exp_err});
      check("rd_count", {496'd0, rd_count}, {496'd0, cnt_exp(exp_rd)});
      check("wr_count", {496'd0, wr_count}, {496'd0, cnt_exp(exp_wr)});
      if (k == inj) begin
        mem_read_req  = 1'($urandom_range(0, 1));
        mem_write_req = !mem_read_req || 1'($urandom_range(0, 1));
        mem_addr = $urandom; mem_wdata = $urandom;
        exp_err = 1'b1;
      end
      @(negedge clk);
    end
    mem_read_req = 1'b0; mem_write_req = 1'b0;
    check("ready_idle", {511'd0, mem_ready}, 512'd0);
    check("busy_idle", {511'd0, mem_busy}, 512'd0);
    check("rdata_hold", mem_rdata, last_rd);
    check("req_err_idle", {511'd0, req_err}, {511'd0, exp_err});
  endtask

  task automatic b_op(input bit rd, input logic [31:0] addr, input logic [31:0] data);
    int ln, wd;
    ln = int'(addr[13:6]);
    wd = int'(addr[5:2]);
    b_read_req = rd; b_write_req = !rd; b_addr = addr; b_wdata = data;
    @(negedge clk);
    b_read_req = 1'b0; b_write_req = 1'b0;
    if (rd) b_rd++; else begin mdl1[ln][wd] = data; b_wr++; end
    check("l1_ready", {511'd0, b_ready}, 512'd1);
    check("l1_busy", {511'd0, b_busy}, 512'd0);
    if (rd) check($sformatf("l1_rdata_line%0d", ln), b_rdata, line1(ln));
    @(negedge clk);
    check("l1_ready_idle", {511'd0, b_ready}, 512'd0);
    check("l1_busy_idle", {511'd0, b_busy}, 512'd0);
  endtask

  function automatic logic [31:0] rnd_addr(input int ln, input int w);
    return {18'($urandom), 8'(ln), 4'(w), 2'($urandom)};
  endfunction

  initial begin
    logic [31:0] old_word;
    rst = 1'b1;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_read_req = 1'b0; mem_write_req = 1'b0;
    b_addr = 32'h0; b_wdata = 32'h0; b_read_req = 1'b0; b_write_req = 1'b0;
    exp_err = 1'b0; exp_rd = 0; exp_wr = 0; b_rd = 0; b_wr = 0; last_rd = '0;

    // Strobes during reset must be ignored.
    @(negedge clk);
    mem_write_req = 1'b1; mem_addr = 32'h0;
    @(negedge clk);
    mem_write_req = 1'b0;
    rst = 1'b0;
    check("rst_ready", {511'd0, mem_ready}, 512'd0);
    check("rst_busy", {511'd0, mem_busy}, 512'd0);
    check("rst_rdata", mem_rdata, 512'd0);
    check("rst_err", {511'd0, req_err}, 512'd0);
    check("rst_rd_count", {496'd0, rd_count}, 512'd0);
    check("rst_wr_count", {496'd0, wr_count}, 512'd0);
    @(negedge clk);
    check("post_rst_busy", {511'd0, mem_busy}, 512'd0);

    for (int ln = 0; ln < 8; ln++)
      for (int w = 0; w < 16; w++) do_op(1'b0, 1'b1, rnd_addr(ln, w), $urandom, 0);

    do_op(1'b0, 1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 0);
    do_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0);
    check("word2_deadbeef", {480'd0, mem_rdata[95:64]}, {480'd0, 32'hDEAD_BEEF});

    do_op(1'b1, 1'b1, 32'h0000_0080, $urandom, 2);
    do_op(1'b1, 1'b0, 32'h0000_0080, 32'h0, 0);
    do_op(1'b1, 1'b0, 32'h0000_4040, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      int r, inj;
      r = $urandom_range(0, 9);
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, L) : 0;
      do_op(r < 5 || r == 9, r >= 5, rnd_addr($urandom_range(0, 7), $urandom_range(0, 15)), $urandom, inj);
    end

    // Write aborted by reset in c2: never completes, never commits.
    old_word = mdl[4][0];
    mem_write_req = 1'b1; mem_addr = 32'h0000_0100; mem_wdata = ~old_word;
    @(negedge clk);
    mem_write_req = 1'b0;
    check("abort_ready_c1", {511'd0, mem_ready}, 512'd0);
    @(negedge clk);
    check("abort_ready_c2", {511'd0, mem_ready}, 512'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0; exp_rd = 0; exp_wr = 0; last_rd = '0;
    check("abort_ready", {511'd0, mem_ready}, 512'd0);
    check("abort_busy", {511'd0, mem_busy}, 512'd0);
    check("abort_rdata", mem_rdata, 512'd0);
    check("abort_err", {511'd0, req_err}, 512'd0);
    check("abort_rd_count", {496'd0, rd_count}, 512'd0);
    check("abort_wr_count", {496'd0, wr_count}, 512'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_ready", {511'd0, mem_ready}, 512'd0);
    end
    do_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0);
    check("abort_old_word", {480'd0, mem_rdata[31:0]}, {480'd0, old_word});

    for (int i = 0; i < 5; i++) do_op(1'b0, 1'b1, rnd_addr($urandom_range(0, 7), $urandom_range(0, 15)), $urandom, 0);
    for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, rnd_addr($urandom_range(0, 7), 0), 32'h0, 0);

    for (int w = 0; w < 16; w++) begin
      b_op(1'b0, rnd_addr(3, w), $urandom);
      b_op(1'b0, rnd_addr(5, w), $urandom);
    end
    b_op(1'b1, rnd_addr(3, 0), 32'h0);
    b_op(1'b1, rnd_addr(5, 0), 32'h0);
    check("l1_err", {511'd0, b_err}, 512'd0);
    check("l1_rd_count", {496'd0, b_rd_count}, {496'd0, cnt_exp(b_rd)});
    check("l1_wr_count", {496'd0, b_wr_count}, {496'd0, cnt_exp(b_wr)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
